uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  Serial transmit engine that sits directly downstream of the uart_apb register block.
//  Accepts one byte per tx_start strobe and drives it on the tx line as an async UART frame:
//  start bit, data LSB-first, optional parity, 1 or 2 stop bits.
//  Reports tx_busy back to the APB status register and pulses tx_done at frame end.
// PARAMETERS
//  CLK_FREQ   50_000_000  PCLK frequency in Hz
//  BAUD       115200      line rate in bit/s; DIV = CLK_FREQ/BAUD (integer div, 434 at defaults)
//  PARITY_EN  0           1 = insert parity bit after data bits
//  PARITY_ODD 0           parity sense when PARITY_EN=1: 0 = even, 1 = odd
//  STOP_BITS  1           number of stop bits; legal values 1 or 2
// PORTS
//  PCLK      in   1  clock, all logic on rising edge
//  PRESET    in   1  synchronous reset, active-high
//  tx_start  in   1  request to send tx_data; honoured only when idle
//  tx_data   in   8  byte to send, sampled on the accepting edge only
//  tx        out  1  serial line, idle high
//  tx_busy   out  1  high from the edge after accept until the frame ends
//  tx_done   out  1  one-cycle pulse at frame completion
// BEHAVIOUR
//  - Reset values: tx=1, tx_busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0.
//  - Reset mid-frame: on the next edge return to reset values. No tx_done. Frame is abandoned.
//  - Registered outputs only; no combinational path from inputs to outputs.
//  - Frame states: IDLE -> START -> DATA(x8) -> [PARITY] -> STOP(xSTOP_BITS) -> IDLE.
//  - Accept: on an edge with state==IDLE && tx_start==1:
//      * latch tx_data into the shift register;
//      * next state START, tx=0, tx_busy=1, counter=0.
//  - tx_start while busy is ignored entirely. No queueing, and tx_data is not re-sampled.
//  - Bit timing: each bit is held exactly DIV cycles.
//      * Counter runs 0..DIV-1; the edge at DIV-1 advances to the next bit and clears the counter.
//  - DATA: bit index 0..7, LSB first. Index wraps to 0 on leaving DATA.
//  - PARITY: the bit is the XOR of the latched byte, inverted when PARITY_ODD=1.
//  - STOP: tx=1. After the last stop bit's DIV cycles the next state is IDLE:
//      * tx_busy=0 and tx_done=1 for exactly that one cycle.
//  - Frame length = (1 + 8 + PARITY_EN + STOP_BITS) * DIV cycles from accept to tx_done.
//  - Back-to-back: tx_start held high in the tx_done cycle is accepted on the following edge.
//      * The stop level therefore lasts DIV+1 cycles between consecutive frames.
//  - Elaboration-time error if DIV < 2 or STOP_BITS is not in {1,2}.
// STRUCTURE
//  - uart_pkg (shared with uart_apb and the receiver):
//      * typedef enum uart_state_t {IDLE, START, DATA, PARITY, STOP};
//      * function baud_div(clk, baud);
//      * localparams UART_DATA_BITS=8, UART_IDLE_LEVEL=1'b1.
//  - One sub-module, uart_baud_tick: counter of width $clog2(DIV).
//      * Synchronous clear input; outputs a one-cycle tick at count DIV-1.
//      * The receiver reuses it for its timing.
//  - Top: state register, bit index, 8-bit shift register, parity accumulator, output flops.
// TESTING
//  - 8N1, send 0xA5 -> tx=0 for 434 cycles, then bits 1,0,1,0,0,1,0,1 at 434 cycles each,
//    then stop=1; tx_done 4340 cycles after accept.
//  - Start 0xA5; pulse tx_start with tx_data=0x3C 1000 cycles later -> line still carries 0xA5,
//    one tx_done only.
//  - Back-to-back 0x00 then 0xFF with tx_start held -> second start-bit falling edge 4341 cycles
//    after the first accept; two tx_done pulses.
//  - PARITY_EN=1, even: 0xA5 -> parity 0; 0x07 -> parity 1.
//      * PARITY_ODD=1 with 0xA5 -> parity 1. tx_done at 4774 cycles.
//  - STOP_BITS=2, 0x5A -> tx high for 868 cycles after data; tx_done at 4774 cycles after accept.
//  - Assert PRESET during data bit 3 of 0xA5 -> next cycle tx=1, tx_busy=0, no tx_done.
//      * A new tx_start after release sends a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, line constants and baud divisor helper.
// Used by the transmitter, the APB register block and the receiver.
package uart_pkg;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   function automatic int baud_div(input int clk, input int baud);
      return clk / baud;
   endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Handshake between the APB register block (master) and the transmit engine (slave).
interface uart_tx_serializer_if;
   import uart_pkg::*;

   logic                      tx_start;
   logic [UART_DATA_BITS-1:0] tx_data;
   logic                      tx;
   logic                      tx_busy;
   logic                      tx_done;

   modport master (
      output tx_start, tx_data,
      input  tx, tx_busy, tx_done
   );

   modport slave (
      input  tx_start, tx_data,
      output tx, tx_busy, tx_done
   );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIV-1 while enabled and flags the last cycle of each bit.
// Shared with the receiver for its sampling timing.
module uart_baud_tick #(
   parameter int DIV = 434
) (
   input  logic PCLK,
   input  logic PRESET,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge PCLK) begin
      if (PRESET || clr || tick) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// All outputs are registered; tx_start is only honoured while idle.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input logic                 PCLK,
   input logic                 PRESET,
   uart_tx_serializer_if.slave bus
);

   localparam int               DIV      = baud_div(CLK_FREQ, BAUD);
   localparam int               IDX_W    = $clog2(UART_DATA_BITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);
   localparam logic             LAST_STP = 1'(STOP_BITS - 1);

   if (DIV < 2) begin : g_bad_div
      $error("uart_tx_serializer: CLK_FREQ/BAUD must be at least 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
   end

   uart_state_t               state_q, state_n;
   logic [IDX_W-1:0]          bit_idx_q, bit_idx_n;
   logic                      stop_idx_q, stop_idx_n;
   logic [UART_DATA_BITS-1:0] shreg_q, shreg_n;
   logic                      par_q, par_n;
   logic                      tx_q, tx_n;
   logic                      busy_q, busy_n;
   logic                      done_q, done_n;
   logic                      tick;

   uart_baud_tick #(
      .DIV (DIV)
   ) u_baud (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .clr    (state_q == IDLE),
      .en     (state_q != IDLE),
      .tick   (tick)
   );

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q    <= IDLE;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         tx_q       <= UART_IDLE_LEVEL;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_n;
         bit_idx_q  <= bit_idx_n;
         stop_idx_q <= stop_idx_n;
         tx_q       <= tx_n;
         busy_q     <= busy_n;
         done_q     <= done_n;
      end
   end

   // Byte and parity only matter once a frame is accepted, so they carry no reset.
   always_ff @(posedge PCLK) begin
      shreg_q <= shreg_n;
      par_q   <= par_n;
   end

   always_comb begin
      state_n    = state_q;
      bit_idx_n  = bit_idx_q;
      stop_idx_n = stop_idx_q;
      shreg_n    = shreg_q;
      par_n      = par_q;
      tx_n       = tx_q;
      busy_n     = busy_q;
      done_n     = 1'b0;

      unique case (state_q)
         IDLE: begin
            tx_n   = UART_IDLE_LEVEL;
            busy_n = 1'b0;
            if (bus.tx_start) begin
               state_n = START;
               shreg_n = bus.tx_data;
               par_n   = (^bus.tx_data) ^ (PARITY_ODD != 0);
               tx_n    = ~UART_IDLE_LEVEL;
               busy_n  = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               state_n   = DATA;
               bit_idx_n = '0;
               tx_n      = shreg_q[0];
            end
         end
         DATA: begin
            if (tick) begin
               shreg_n = {1'b0, shreg_q[UART_DATA_BITS-1:1]};
               if (bit_idx_q == LAST_IDX) begin
                  bit_idx_n = '0;
                  if (PARITY_EN != 0) begin
                     state_n = PARITY;
                     tx_n    = par_q;
                  end else begin
                     state_n    = STOP;
                     stop_idx_n = 1'b0;
                     tx_n       = UART_IDLE_LEVEL;
                  end
               end else begin
                  bit_idx_n = bit_idx_q + IDX_W'(1);
                  tx_n      = shreg_q[1];
               end
            end
         end
         PARITY: begin
            if (tick) begin
               state_n    = STOP;
               stop_idx_n = 1'b0;
               tx_n       = UART_IDLE_LEVEL;
            end
         end
         STOP: begin
            tx_n = UART_IDLE_LEVEL;
            if (tick) begin
               if (stop_idx_q == LAST_STP) begin
                  state_n    = IDLE;
                  stop_idx_n = 1'b0;
                  busy_n     = 1'b0;
                  done_n     = 1'b1;
               end else begin
                  stop_idx_n = 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            tx_n    = UART_IDLE_LEVEL;
            busy_n  = 1'b0;
         end
      endcase
   end

   assign bus.tx      = tx_q;
   assign bus.tx_busy = busy_q;
   assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: four instances (8N1, 8E1, 8O1, 8N2) at default baud.
module tb_uart_tx_serializer;

   localparam int DIV  = 434;
   localparam int HALF = DIV / 2;

   typedef struct packed {
      int         inst;
      logic [11:0] seq;      // bits after the start bit, seq[0] first on the line
      int         n;
      int         done_at;   // cycles from accept to tx_done
      int         gap;       // required spacing from previous start, 0 = unchecked
      logic       abort;     // frame is cut by reset
   } frame_t;

   logic       clk = 1'b0;
   logic       start_r [4];
   logic [7:0] data_r  [4];
   logic       rst_r   [4];
   logic       tx_w    [4];
   logic       busy_w  [4];
   logic       done_w  [4];
   longint     cyc = 0;
   bit         init_done = 1'b0;
   int         total = 0;
   int         bad = 0;
   frame_t     sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[u%0d]: got %0d (0x%0h) expected %0d (0x%0h)", name, inst, act, act, exp, exp);
      end
   endtask

   task automatic fail(input string name, input int inst);
      total++;
      bad++;
      $display("FAIL %s[u%0d]: event not expected", name, inst);
   endtask

   function automatic int find(input int inst);
      foreach (sb[j]) if (sb[j].inst == inst) return j;
      return -1;
   endfunction

   for (genvar i = 0; i < 4; i++) begin : g_dut
      uart_tx_serializer_if bus();
      int done_cnt = 0;

      assign bus.tx_start = start_r[i];
      assign bus.tx_data  = data_r[i];
      assign tx_w[i]      = bus.tx;
      assign busy_w[i]    = bus.tx_busy;
      assign done_w[i]    = bus.tx_done;

      uart_tx_serializer #(
         .CLK_FREQ   (50_000_000),
         .BAUD       (115200),
         .PARITY_EN  ((i == 1 || i == 2) ? 1 : 0),
         .PARITY_ODD ((i == 2) ? 1 : 0),
         .STOP_BITS  ((i == 3) ? 2 : 1)
      ) u_dut (
         .PCLK   (clk),
         .PRESET (rst_r[i]),
         .bus    (bus.slave)
      );

      always @(negedge clk) if (init_done && done_w[i] === 1'b1) done_cnt <= done_cnt + 1;

      initial begin : mon
         logic   prev;
         frame_t e;
         int     idx;
         int     k;
         bit     got;
         longint t0;
         longint last_t0;
         prev    = 1'b1;
         last_t0 = 0;
         wait (init_done);
         forever begin
            @(posedge clk);
            #1;
            if (tx_w[i] === 1'b0 && prev === 1'b1) begin
               idx = find(i);
               if (idx < 0) begin
                  fail("unexpected_frame", i);
               end else begin
                  e = sb[idx];
                  sb.delete(idx);
                  t0 = cyc;
                  if (e.gap > 0) chk("start_gap", i, 32'(t0 - last_t0), e.gap);
                  last_t0 = t0;
                  chk("busy_on", i, busy_w[i], 1);
                  k   = 0;
                  got = 1'b0;
                  for (int m = 1; m <= e.done_at + 10; m++) begin
                     @(posedge clk);
                     #1;
                     if (rst_r[i] === 1'b1) begin
                        if (e.abort) begin
                           chk("rst_tx", i, tx_w[i], 1);
                           chk("rst_busy", i, busy_w[i], 0);
                           chk("rst_done", i, done_w[i], 0);
                        end else begin
                           fail("unexpected_reset", i);
                        end
                        got = 1'b1;
                        break;
                     end
                     if (m == HALF) begin
                        chk("start_bit", i, tx_w[i], 0);
                     end else if (m > HALF && (m - HALF) % DIV == 0 && k < e.n) begin
                        chk($sformatf("bit%0d", k), i, tx_w[i], e.seq[k]);
                        k++;
                     end
                     if (done_w[i] === 1'b1) begin
                        if (e.abort) fail("done_after_reset", i);
                        chk("done_time", i, m, e.done_at);
                        chk("busy_off", i, busy_w[i], 0);
                        chk("tx_idle", i, tx_w[i], 1);
                        got = 1'b1;
                        break;
                     end
                  end
                  if (!got) fail("done_timeout", i);
               end
            end
            prev = tx_w[i];
         end
      end
   end

   task automatic push(input int inst, input logic [11:0] seq, input int n, input int done_at,
                       input int gap, input logic abort);
      frame_t e;
      e.inst    = inst;
      e.seq     = seq;
      e.n       = n;
      e.done_at = done_at;
      e.gap     = gap;
      e.abort   = abort;
      sb.push_back(e);
   endtask

   task automatic send(input int inst, input logic [7:0] b, input logic [11:0] seq, input int n,
                       input int done_at, input logic abort);
      push(inst, seq, n, done_at, 0, abort);
      @(negedge clk);
      start_r[inst] = 1'b1;
      data_r[inst]  = b;
      @(negedge clk);
      start_r[inst] = 1'b0;
      data_r[inst]  = ~b;
   endtask

   initial begin : watchdog
      #800000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      for (int i = 0; i < 4; i++) begin
         start_r[i] = 1'b0;
         data_r[i]  = 8'h00;
         rst_r[i]   = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk("reset_tx", i, tx_w[i], 1);
         chk("reset_busy", i, busy_w[i], 0);
         chk("reset_done", i, done_w[i], 0);
      end
      for (int i = 0; i < 4; i++) rst_r[i] = 1'b0;
      init_done = 1'b1;
      @(negedge clk);

      fork
         begin : seq_u0
            // plain 8N1 frame
            send(0, 8'hA5, 12'h1A5, 9, 4340, 1'b0);
            repeat (4360) @(negedge clk);
            // request while busy must be dropped
            send(0, 8'hA5, 12'h1A5, 9, 4340, 1'b0);
            repeat (1000) @(negedge clk);
            start_r[0] = 1'b1;
            data_r[0]  = 8'h3C;
            @(negedge clk);
            start_r[0] = 1'b0;
            repeat (3400) @(negedge clk);
            // back-to-back with tx_start held through tx_done
            push(0, 12'h100, 9, 4340, 0, 1'b0);
            @(negedge clk);
            start_r[0] = 1'b1;
            data_r[0]  = 8'h00;
            @(negedge clk);
            data_r[0]  = 8'hFF;
            push(0, 12'h1FF, 9, 4340, 4341, 1'b0);
            repeat (4345) @(negedge clk);
            start_r[0] = 1'b0;
            repeat (4360) @(negedge clk);
            // reset during data bit 3, then a clean frame
            send(0, 8'hA5, 12'h1A5, 9, 4340, 1'b1);
            repeat (1900) @(negedge clk);
            rst_r[0] = 1'b1;
            @(negedge clk);
            rst_r[0] = 1'b0;
            repeat (50) @(negedge clk);
            send(0, 8'hA5, 12'h1A5, 9, 4340, 1'b0);
            repeat (4360) @(negedge clk);
         end
         begin : seq_u1
            send(1, 8'hA5, 12'h2A5, 10, 4774, 1'b0);
            repeat (4790) @(negedge clk);
            send(1, 8'h07, 12'h307, 10, 4774, 1'b0);
            repeat (4790) @(negedge clk);
         end
         begin : seq_u2
            send(2, 8'hA5, 12'h3A5, 10, 4774, 1'b0);
            repeat (4790) @(negedge clk);
         end
         begin : seq_u3
            send(3, 8'h5A, 12'h35A, 10, 4774, 1'b0);
            repeat (4790) @(negedge clk);
         end
      join

      repeat (20) @(negedge clk);
      chk("done_count", 0, g_dut[0].done_cnt, 5);
      chk("done_count", 1, g_dut[1].done_cnt, 2);
      chk("done_count", 2, g_dut[2].done_cnt, 1);
      chk("done_count", 3, g_dut[3].done_cnt, 1);
      chk("sb_empty", 0, sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
